// File: rtl/bound_flasher_param_if.sv
// Control/status bundle between a bound flasher and its driver.
// The driver supplies flick/step/repeat; the flasher returns the LED bar and status.
interface bound_flasher_param_if #(
  parameter int W = 16
);
  logic         flick;
  logic         step_en;
  logic         auto_repeat;
  logic [W-1:0] LED;
  logic         busy;
  logic [2:0]   phase;
  logic         done;

  modport master (
    output flick, step_en, auto_repeat,
    input  LED, busy, phase, done
  );

  modport slave (
    input  flick, step_en, auto_repeat,
    output LED, busy, phase, done
  );
endinterface

// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: W-bit thermometer bar swept through six up/down
// phases with flick kickback at the intermediate peaks, step-enable and auto-repeat.
module bound_flasher_param #(
  parameter int W   = 16,
  parameter int K1  = 6,
  parameter int K2  = 11,
  parameter int KLO = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bound_flasher_param_if.slave  bus
);
  localparam int LW = $clog2(W + 1);

  if (W < 4 || W > 64 || KLO < 1 || KLO >= K1 || K1 >= K2 || K2 >= W) begin : g_bad_params
    $error("bound_flasher_param: illegal parameters W=%0d K1=%0d K2=%0d KLO=%0d",
           W, K1, K2, KLO);
  end

  typedef enum logic {IDLE, ACTIVE} run_t;

  run_t          run_q, run_d;
  logic [2:0]    idx_q, idx_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          done_d;
  logic [LW-1:0] target;
  logic          up;
  logic          at_peak;
  logic [W-1:0]  led_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= IDLE;
      idx_q     <= '0;
      lvl_q     <= '0;
      bus.LED   <= '0;
      bus.busy  <= 1'b0;
      bus.phase <= '0;
      bus.done  <= 1'b0;
    end else begin
      run_q     <= run_d;
      idx_q     <= idx_d;
      lvl_q     <= lvl_d;
      bus.LED   <= led_d;
      bus.busy  <= (run_d == ACTIVE);
      bus.phase <= (run_d == ACTIVE) ? idx_d : '0;
      bus.done  <= done_d;
    end
  end

  // Even phases climb, odd phases fall; each has a fixed target level.
  always_comb begin
    target = '0;
    case (idx_q)
      3'd0:    target = LW'(K1);
      3'd2:    target = LW'(K2);
      3'd3:    target = LW'(KLO);
      3'd4:    target = LW'(W);
      default: target = '0;
    endcase
  end

  assign up      = ~idx_q[0];
  assign at_peak = (lvl_q == LW'(K1)) || (lvl_q == LW'(K2));

  always_comb begin
    run_d  = run_q;
    idx_d  = idx_q;
    lvl_d  = lvl_q;
    done_d = 1'b0;
    if (bus.step_en) begin
      if (run_q == IDLE) begin
        if (bus.flick) begin
          run_d = ACTIVE;
          idx_d = 3'd0;
          lvl_d = LW'(1);
        end
      end else if (up) begin
        if (idx_q != 3'd0 && bus.flick && at_peak) begin
          idx_d = idx_q - 3'd1;
          lvl_d = lvl_q - LW'(1);
        end else if (lvl_q < target) begin
          lvl_d = lvl_q + LW'(1);
        end else begin
          idx_d = idx_q + 3'd1;
          lvl_d = lvl_q - LW'(1);
        end
      end else begin
        if (lvl_q > target) begin
          lvl_d = lvl_q - LW'(1);
        end else if (idx_q != 3'd5) begin
          idx_d = idx_q + 3'd1;
          lvl_d = lvl_q + LW'(1);
        end else begin
          done_d = 1'b1;
          idx_d  = 3'd0;
          if (bus.auto_repeat) begin
            lvl_d = LW'(1);
          end else begin
            run_d = IDLE;
            lvl_d = '0;
          end
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < W; i++) begin
      led_d[i] = (lvl_d > LW'(i));
    end
  end
endmodule
